// File: rtl/fetch_unit_if.sv
// fetch_unit_if: IF stage with one-entry stall buffer, flush redirect and discard of an in-flight request.
module fetch_unit_if (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] pc,
  output logic        pc_enable,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        flush,
  output logic        id_valid,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc4
);
  typedef enum logic [1:0] {FETCH, HOLD, DISCARD} state_t;
  state_t state, state_nx;
  logic [31:0] buf_instr, buf_pc4, discard_addr;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= FETCH;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    case (state)
      FETCH:   state_nx = flush ? (imem_ready ? FETCH : DISCARD) : (imem_ready && stall ? HOLD : FETCH);
      HOLD:    state_nx = flush || !stall ? FETCH : HOLD;
      DISCARD: state_nx = imem_ready ? FETCH : DISCARD;
      default: state_nx = FETCH;
    endcase
  end
  always_comb begin
    imem_req  = state != HOLD;
    imem_addr = state == DISCARD ? discard_addr : pc;
    pc_enable = state == FETCH ? (flush || imem_ready) : (state == HOLD && flush);
  end
  // The stall buffer is full exactly while in HOLD, so no separate valid bit is kept.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      id_valid     <= 1'b0;
      id_instr     <= 32'h0;
      id_pc4       <= 32'h0;
      buf_instr    <= 32'h0;
      buf_pc4      <= 32'h0;
      discard_addr <= 32'h0;
    end else if (flush) begin
      id_valid <= 1'b0;
      id_instr <= 32'h0;
      id_pc4   <= 32'h0;
      if (state == FETCH && !imem_ready) discard_addr <= pc;
    end else if (state == FETCH && imem_ready && !stall) begin
      id_valid <= 1'b1;
      id_instr <= imem_rdata;
      id_pc4   <= pc + 32'd4;
    end else if (state == FETCH && imem_ready) begin
      buf_instr <= imem_rdata;
      buf_pc4   <= pc + 32'd4;
    end else if (state == HOLD && !stall) begin
      id_valid <= 1'b1;
      id_instr <= buf_instr;
      id_pc4   <= buf_pc4;
    end
endmodule

// File: tb/tb_fetch_unit_if.sv
// tb_fetch_unit_if: directed scenarios with a queue of expected IF/ID loads.
module tb_fetch_unit_if;
  logic        clk = 0, rst_n = 0, imem_ready = 0, stall = 0, flush = 0;
  logic [31:0] pc = 0, imem_rdata = 0;
  logic        pc_enable, imem_req, id_valid;
  logic [31:0] imem_addr, id_instr, id_pc4;
  logic [63:0] q[$];
  logic [63:0] e;
  int n_cmp = 0, n_err = 0;

  fetch_unit_if dut (
    .clk(clk), .rst_n(rst_n), .pc(pc), .pc_enable(pc_enable),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
    .imem_rdata(imem_rdata), .stall(stall), .flush(flush),
    .id_valid(id_valid), .id_instr(id_instr), .id_pc4(id_pc4)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] p, input logic r, input logic [31:0] d, input logic s, input logic f);
    pc = p; imem_ready = r; imem_rdata = d; stall = s; flush = f;
    #1;
  endtask

  task automatic pop_cmp(input string tag);
    n_cmp++;
    if (q.size() == 0) begin
      n_err++; $display("FAIL %s: scoreboard empty", tag);
    end else begin
      e = q.pop_front();
      if ({id_valid, id_instr, id_pc4} !== {1'b1, e}) begin
        n_err++;
        $display("FAIL %s: got v=%0b instr=%h pc4=%h, want v=1 instr=%h pc4=%h", tag, id_valid, id_instr, id_pc4, e[63:32], e[31:0]);
      end
    end
  endtask

  task automatic test_reset;
    drive(32'h0, 0, 0, 0, 0);
    n_cmp++; if ({id_valid, id_instr, id_pc4} !== 65'h0) begin n_err++; $display("FAIL reset_ifid: got %h want 0", {id_valid, id_instr, id_pc4}); end
    n_cmp++; if ({imem_req, pc_enable, imem_addr} !== {1'b1, 1'b0, 32'h0}) begin n_err++; $display("FAIL reset_outs: got req=%0b en=%0b addr=%h want 1 0 0", imem_req, pc_enable, imem_addr); end
    #2 rst_n = 1;
  endtask

  task automatic test_zero_wait;
    logic [31:0] w[3] = '{32'hAAAA_0001, 32'hBBBB_0002, 32'hCCCC_0003};
    for (int i = 0; i < 3; i++) begin
      drive(32'(4 * i), 1, w[i], 0, 0);
      n_cmp++; if ({pc_enable, imem_addr} !== {1'b1, 32'(4 * i)}) begin n_err++; $display("FAIL zw_en[%0d]: got en=%0b addr=%h want 1 %h", i, pc_enable, imem_addr, 4 * i); end
      q.push_back({w[i], 32'(4 * i + 4)});
      tick;
      pop_cmp($sformatf("zw_load[%0d]", i));
    end
  endtask

  task automatic test_wait;
    for (int i = 0; i < 3; i++) begin
      drive(32'h10, 0, 32'hBAD0_0000, 0, 0);
      n_cmp++; if ({imem_req, pc_enable, imem_addr} !== {1'b1, 1'b0, 32'h10}) begin n_err++; $display("FAIL wait_hold[%0d]: got req=%0b en=%0b addr=%h want 1 0 10", i, imem_req, pc_enable, imem_addr); end
      tick;
      n_cmp++; if (id_instr !== 32'hCCCC_0003) begin n_err++; $display("FAIL wait_ifid[%0d]: got %h want cccc0003", i, id_instr); end
    end
    drive(32'h10, 1, 32'h1111_0010, 0, 0);
    n_cmp++; if (pc_enable !== 1'b1) begin n_err++; $display("FAIL wait_ready_en: got %0b want 1", pc_enable); end
    q.push_back({32'h1111_0010, 32'h14});
    tick;
    pop_cmp("wait_load");
  endtask

  task automatic test_stall_hold;
    drive(32'h20, 1, 32'hDDDD_0020, 1, 0);
    n_cmp++; if (pc_enable !== 1'b1) begin n_err++; $display("FAIL stall_cap_en: got %0b want 1", pc_enable); end
    tick;
    for (int i = 0; i < 2; i++) begin
      drive(32'h24, 0, 0, 1, 0);
      n_cmp++; if ({imem_req, pc_enable, id_instr} !== {2'b00, 32'h1111_0010}) begin n_err++; $display("FAIL hold[%0d]: got req=%0b en=%0b instr=%h want 0 0 11110010", i, imem_req, pc_enable, id_instr); end
      tick;
    end
    drive(32'h24, 0, 0, 0, 0);
    q.push_back({32'hDDDD_0020, 32'h24});
    tick;
    pop_cmp("hold_release");
    drive(32'h24, 0, 0, 0, 0);
    n_cmp++; if (imem_req !== 1'b1) begin n_err++; $display("FAIL hold_back_fetch: got req=%0b want 1", imem_req); end
  endtask

  task automatic test_flush_discard;
    drive(32'h30, 0, 0, 0, 1);
    n_cmp++; if (pc_enable !== 1'b1) begin n_err++; $display("FAIL fl_en: got %0b want 1", pc_enable); end
    tick;
    n_cmp++; if ({id_valid, id_instr, id_pc4} !== 65'h0) begin n_err++; $display("FAIL fl_clear: got %h want 0", {id_valid, id_instr, id_pc4}); end
    drive(32'h100, 0, 0, 0, 0);
    n_cmp++; if ({imem_req, pc_enable, imem_addr} !== {1'b1, 1'b0, 32'h30}) begin n_err++; $display("FAIL disc_addr: got req=%0b en=%0b addr=%h want 1 0 30", imem_req, pc_enable, imem_addr); end
    tick;
    drive(32'h100, 0, 0, 0, 1);
    n_cmp++; if ({pc_enable, imem_addr} !== {1'b0, 32'h30}) begin n_err++; $display("FAIL disc_reflush: got en=%0b addr=%h want 0 30", pc_enable, imem_addr); end
    tick;
    drive(32'h100, 1, 32'hDEAD_DEAD, 0, 0);
    n_cmp++; if ({pc_enable, imem_addr} !== {1'b0, 32'h30}) begin n_err++; $display("FAIL disc_ready: got en=%0b addr=%h want 0 30", pc_enable, imem_addr); end
    tick;
    n_cmp++; if ({id_valid, id_instr} !== 33'h0) begin n_err++; $display("FAIL disc_drop: got v=%0b instr=%h want 0 0", id_valid, id_instr); end
    drive(32'h100, 0, 0, 0, 0);
    n_cmp++; if ({imem_req, pc_enable, imem_addr} !== {1'b1, 1'b0, 32'h100}) begin n_err++; $display("FAIL disc_redir: got req=%0b en=%0b addr=%h want 1 0 100", imem_req, pc_enable, imem_addr); end
    drive(32'h100, 1, 32'hEEEE_0100, 0, 0);
    q.push_back({32'hEEEE_0100, 32'h104});
    tick;
    pop_cmp("disc_next");
  endtask

  task automatic test_flush_hold;
    drive(32'h40, 1, 32'hFFFF_0040, 1, 0);
    tick;
    drive(32'h44, 0, 0, 1, 1);
    n_cmp++; if ({imem_req, pc_enable} !== 2'b01) begin n_err++; $display("FAIL fh_en: got req=%0b en=%0b want 0 1", imem_req, pc_enable); end
    tick;
    n_cmp++; if ({id_valid, id_instr, id_pc4} !== 65'h0) begin n_err++; $display("FAIL fh_clear: got %h want 0", {id_valid, id_instr, id_pc4}); end
    drive(32'h200, 0, 0, 0, 0);
    n_cmp++; if ({imem_req, imem_addr} !== {1'b1, 32'h200}) begin n_err++; $display("FAIL fh_fetch: got req=%0b addr=%h want 1 200", imem_req, imem_addr); end
    tick;
    n_cmp++; if (id_valid !== 1'b0) begin n_err++; $display("FAIL fh_nostale: got v=%0b want 0", id_valid); end
    drive(32'h200, 1, 32'h6666_0200, 0, 0);
    q.push_back({32'h6666_0200, 32'h204});
    tick;
    pop_cmp("fh_next");
  endtask

  task automatic test_pc_wrap;
    drive(32'hFFFF_FFFC, 1, 32'h7777_FFFC, 0, 0);
    q.push_back({32'h7777_FFFC, 32'h0});
    tick;
    pop_cmp("pc_wrap");
  endtask

  task automatic test_back_to_back;
    for (int i = 0; i < 8; i++) begin
      logic [31:0] d = $urandom;
      drive(32'h400 + 32'(4 * i), 1, d, 0, 0);
      q.push_back({d, 32'h404 + 32'(4 * i)});
      tick;
      pop_cmp($sformatf("b2b[%0d]", i));
    end
  endtask

  task automatic test_reset_mid;
    drive(32'h50, 0, 0, 0, 0);
    tick;
    rst_n = 0;
    #1;
    n_cmp++; if ({id_valid, id_instr, id_pc4} !== 65'h0) begin n_err++; $display("FAIL rst_wait: got %h want 0", {id_valid, id_instr, id_pc4}); end
    rst_n = 1;
    drive(32'h60, 1, 32'h9999_0060, 1, 0);
    tick;
    drive(32'h64, 0, 0, 1, 0);
    n_cmp++; if (imem_req !== 1'b0) begin n_err++; $display("FAIL rst_pre_hold: got req=%0b want 0", imem_req); end
    rst_n = 0;
    #1;
    n_cmp++; if ({imem_req, imem_addr, id_valid, id_instr} !== {1'b1, 32'h64, 33'h0}) begin n_err++; $display("FAIL rst_hold: got req=%0b addr=%h v=%0b instr=%h want 1 64 0 0", imem_req, imem_addr, id_valid, id_instr); end
    rst_n = 1;
    drive(32'h64, 0, 0, 0, 0);
    tick;
    tick;
    n_cmp++; if ({id_valid, id_instr} !== 33'h0) begin n_err++; $display("FAIL rst_nostale: got v=%0b instr=%h want 0 0", id_valid, id_instr); end
  endtask

  initial begin
    #3;
    test_reset;
    test_zero_wait;
    test_wait;
    test_stall_hold;
    test_flush_discard;
    test_flush_hold;
    test_pc_wrap;
    test_back_to_back;
    test_reset_mid;
    n_cmp++; if (q.size() != 0) begin n_err++; $display("FAIL sb_leftover: got %0d want 0", q.size()); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
